// File: rtl/jtframe_arb_pkg.sv
// Shared types and helpers for the SDRAM ROM-port arbiter and its grant picker.
package jtframe_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    localparam int MAX_SLOTS = 8;

    // Width of a slot index; never below one bit so two-slot builds still work.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational grant picker: slot 0 always wins, slots 1..SLOTS-1 rotate after rr.
module jtframe_rr_pick
    import jtframe_arb_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int IW    = idx_w(SLOTS)
) (
    input  logic [SLOTS-1:0] pending,
    input  logic [IW-1:0]    rr,
    output logic [SLOTS-1:0] grant,
    output logic [IW-1:0]    grant_idx
);

    logic found;
    int   c;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        c         = 0;
        if (pending[0]) begin
            grant[0] = 1'b1;
            found    = 1'b1;
        end else begin
            // Walk rr+1, rr+2, ... wrapping from SLOTS-1 back to 1, skipping slot 0.
            for (int k = 0; k < SLOTS - 1; k++) begin
                c = int'(rr) + 1 + k;
                if (c > SLOTS - 1) c = c - (SLOTS - 1);
                if (!found && pending[IW'(c)]) begin
                    grant[IW'(c)] = 1'b1;
                    grant_idx     = IW'(c);
                    found         = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/jtframe_sdram_arb.sv
// Shares the game-side SDRAM read port among ROM slots, each with a one-word
// last-address cache; quiesces and flushes during ROM download.
module jtframe_sdram_arb
    import jtframe_arb_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int AW    = 22
) (
    input  logic                clk_sys,
    input  logic                RESET,
    input  logic                loop_rst,
    input  logic                downloading,
    input  logic [SLOTS-1:0]    slot_cs,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [SLOTS*32-1:0] slot_dout,
    output logic                sdram_req,
    output logic [AW-1:0]       sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [31:0]         data_read,
    output logic                refresh_en,
    output arb_state_t          st_dbg
);

    localparam int IW = idx_w(SLOTS);

    // Handshake: sdram_req is a level held with a stable sdram_addr until the
    // cycle sdram_ack pulses (inclusive); data_rdy then pulses once with
    // data_read valid. data_rdy outside a fetch is ignored.

    arb_state_t     state_q, state_d;
    logic [IW-1:0]  cur_q, cur_d;
    logic [IW-1:0]  rr_q, rr_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [SLOTS-1:0] valid_q, valid_d;
    logic [AW-1:0]  tag_q  [SLOTS];
    logic [AW-1:0]  tag_d  [SLOTS];
    logic [31:0]    dout_q [SLOTS];
    logic [31:0]    dout_d [SLOTS];

    logic [AW-1:0]    addr_a [SLOTS];
    logic [SLOTS-1:0] hit, pending, grant;
    logic [IW-1:0]    grant_idx;
    logic [AW-1:0]    grant_addr;
    logic             busy;

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        assign addr_a[g]             = slot_addr[g*AW +: AW];
        assign slot_dout[g*32 +: 32] = dout_q[g];
    end

    assign busy = (state_q != ST_IDLE);

    always_comb begin
        hit     = '0;
        pending = '0;
        for (int i = 0; i < SLOTS; i++) begin
            hit[i]     = valid_q[i] && (tag_q[i] == addr_a[i]);
            pending[i] = slot_cs[i] && !hit[i] && !(busy && cur_q == IW'(i));
        end
    end

    jtframe_rr_pick #(
        .SLOTS     (SLOTS),
        .IW        (IW)
    ) u_pick (
        .pending   (pending),
        .rr        (rr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        grant_addr = '0;
        for (int i = 0; i < SLOTS; i++)
            if (grant[i]) grant_addr = addr_a[i];
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            rr_q    <= IW'(SLOTS - 1);
            addr_q  <= '0;
            valid_q <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                tag_q[i]  <= '0;
                dout_q[i] <= '0;
            end
        end else if (loop_rst) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            rr_q    <= IW'(SLOTS - 1);
            addr_q  <= '0;
            valid_q <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                tag_q[i]  <= '0;
                dout_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            for (int i = 0; i < SLOTS; i++) begin
                tag_q[i]  <= tag_d[i];
                dout_q[i] <= dout_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rr_d    = rr_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        for (int i = 0; i < SLOTS; i++) begin
            tag_d[i]  = tag_q[i];
            dout_d[i] = dout_q[i];
        end
        if (downloading) begin
            state_d = ST_IDLE;
            valid_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|pending) begin
                        cur_d   = grant_idx;
                        addr_d  = grant_addr;
                        if (!grant[0]) rr_d = grant_idx;
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (sdram_ack) state_d = data_rdy ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (data_rdy) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
            // The tag is the address latched at grant, so a slot that moved
            // mid-fetch misses and gets re-requested.
            if (data_rdy && ((state_q == ST_WAIT) || (state_q == ST_REQ && sdram_ack))) begin
                valid_d[cur_q] = 1'b1;
                tag_d[cur_q]   = addr_q;
                dout_d[cur_q]  = data_read;
            end
        end
    end

    always_comb begin
        sdram_req  = (state_q == ST_REQ);
        sdram_addr = addr_q;
        refresh_en = ((state_q == ST_IDLE) && !(|pending)) || downloading;
        slot_ok    = slot_cs & hit;
        st_dbg     = state_q;
    end

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Directed bench for jtframe_sdram_arb: miss/hit timing, priority and rotation,
// mid-fetch address change, download flush, same-cycle ack/data and reset.
module tb_jtframe_sdram_arb;
    import jtframe_arb_pkg::*;

    localparam int SLOTS = 4;
    localparam int AW    = 22;

    logic                clk_sys = 1'b0;
    logic                RESET = 1'b1;
    logic                loop_rst = 1'b0;
    logic                downloading = 1'b0;
    logic [SLOTS-1:0]    slot_cs = '0;
    logic [SLOTS*AW-1:0] slot_addr = '0;
    logic [SLOTS-1:0]    slot_ok;
    logic [SLOTS*32-1:0] slot_dout;
    logic                sdram_req;
    logic [AW-1:0]       sdram_addr;
    logic                sdram_ack = 1'b0;
    logic                data_rdy = 1'b0;
    logic [31:0]         data_read = '0;
    logic                refresh_en;
    arb_state_t          st_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    jtframe_sdram_arb #(.SLOTS(SLOTS), .AW(AW)) dut (
        .clk_sys     (clk_sys),
        .RESET       (RESET),
        .loop_rst    (loop_rst),
        .downloading (downloading),
        .slot_cs     (slot_cs),
        .slot_addr   (slot_addr),
        .slot_ok     (slot_ok),
        .slot_dout   (slot_dout),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .data_read   (data_read),
        .refresh_en  (refresh_en),
        .st_dbg      (st_dbg)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_slot(input int i, input logic cs, input logic [AW-1:0] a);
        slot_cs[i] = cs;
        slot_addr[i*AW +: AW] = a;
    endtask

    function automatic logic [31:0] dout_of(input int i);
        return slot_dout[i*32 +: 32];
    endfunction

    task automatic wait_req();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (sdram_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("req_timeout", 64'(ok), 64'(1));
    endtask

    // Waits for a request, acks it, then returns data one cycle later.
    task automatic serve(input logic [31:0] d, output logic [AW-1:0] a);
        wait_req();
        a = sdram_addr;
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        tick();
        data_rdy  = 1'b1;
        data_read = d;
        tick();
        data_rdy  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        int order1 [4];
        int order2 [3];
        order1 = '{0, 1, 2, 3};
        order2 = '{0, 1, 3};

        // Reset values
        tick(); tick();
        check("rst_req", 64'(sdram_req), 64'(0));
        check("rst_ok", 64'(slot_ok), 64'(0));
        check("rst_refresh", 64'(refresh_en), 64'(1));
        check("rst_addr", 64'(sdram_addr), 64'(0));
        check("rst_dout", 64'(|slot_dout), 64'(0));
        RESET = 1'b0;
        tick();

        // Single miss: ack at +3, data at +6, slot_ok at +7
        set_slot(2, 1'b1, 22'h01234);
        settle();
        check("miss_ok_c0", 64'(slot_ok), 64'(0));
        check("miss_req_c0", 64'(sdram_req), 64'(0));
        check("miss_refresh_c0", 64'(refresh_en), 64'(0));
        tick();
        check("miss_req_c1", 64'(sdram_req), 64'(1));
        check("miss_addr_c1", 64'(sdram_addr), 64'(22'h01234));
        tick();
        tick();
        sdram_ack = 1'b1;
        settle();
        check("miss_req_ack", 64'(sdram_req), 64'(1));
        check("miss_addr_ack", 64'(sdram_addr), 64'(22'h01234));
        tick();
        sdram_ack = 1'b0;
        check("miss_req_c4", 64'(sdram_req), 64'(0));
        check("miss_refresh_wait", 64'(refresh_en), 64'(0));
        tick();
        tick();
        data_rdy  = 1'b1;
        data_read = 32'hDEADBEEF;
        settle();
        check("miss_ok_c6", 64'(slot_ok), 64'(0));
        tick();
        data_rdy = 1'b0;
        check("miss_ok_c7", 64'(slot_ok), 64'(4'b0100));
        check("miss_dout", 64'(dout_of(2)), 64'(32'hDEADBEEF));

        // Hit: cs low holds the data, re-read completes immediately
        set_slot(2, 1'b0, 22'h01234);
        tick();
        check("hold_cs_low", 64'(dout_of(2)), 64'(32'hDEADBEEF));
        check("ok_cs_low", 64'(slot_ok), 64'(0));
        set_slot(2, 1'b1, 22'h01234);
        settle();
        check("hit_ok", 64'(slot_ok), 64'(4'b0100));
        check("hit_refresh", 64'(refresh_en), 64'(1));
        tick();
        check("hit_no_req", 64'(sdram_req), 64'(0));

        // loop_rst clears the cache and restores rr
        loop_rst = 1'b1;
        set_slot(2, 1'b0, 22'h01234);
        tick();
        loop_rst = 1'b0;
        check("lrst_dout", 64'(dout_of(2)), 64'(0));
        set_slot(2, 1'b1, 22'h01234);
        settle();
        check("lrst_ok", 64'(slot_ok), 64'(0));
        slot_cs = '0;
        tick();

        // Priority then round-robin
        for (int i = 0; i < 4; i++) set_slot(i, 1'b1, AW'(22'h100 + i));
        for (int k = 0; k < 4; k++) begin
            serve(32'hC0DE0000 + 32'(order1[k]), a);
            check($sformatf("rr1_addr%0d", k), 64'(a), 64'(22'h100 + order1[k]));
        end
        check("rr1_ok", 64'(slot_ok), 64'(4'b1111));
        for (int i = 0; i < 4; i++)
            check($sformatf("rr1_dout%0d", i), 64'(dout_of(i)), 64'(32'hC0DE0000 + i));
        set_slot(0, 1'b1, 22'h200);
        set_slot(1, 1'b1, 22'h201);
        set_slot(3, 1'b1, 22'h203);
        for (int k = 0; k < 3; k++) begin
            serve(32'hBEEF0000 + 32'(order2[k]), a);
            check($sformatf("rr2_addr%0d", k), 64'(a), 64'(22'h200 + order2[k]));
        end
        check("rr2_ok", 64'(slot_ok), 64'(4'b1111));
        check("rr2_dout3", 64'(dout_of(3)), 64'(32'hBEEF0003));
        check("rr2_dout2", 64'(dout_of(2)), 64'(32'hC0DE0002));
        slot_cs = '0;
        tick();

        // Address change mid-fetch
        set_slot(1, 1'b1, 22'h10);
        wait_req();
        check("mid_addr1", 64'(sdram_addr), 64'(22'h10));
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        set_slot(1, 1'b1, 22'h20);
        tick();
        data_rdy  = 1'b1;
        data_read = 32'h11111111;
        tick();
        data_rdy = 1'b0;
        check("mid_ok_stale", 64'(slot_ok), 64'(0));
        serve(32'h22222222, a);
        check("mid_addr2", 64'(a), 64'(22'h20));
        check("mid_ok", 64'(slot_ok), 64'(4'b0010));
        check("mid_dout", 64'(dout_of(1)), 64'(32'h22222222));
        slot_cs = '0;
        tick();

        // Download during REQ flushes the cache
        set_slot(2, 1'b1, 22'h102);
        settle();
        check("dl_pre_hit", 64'(slot_ok), 64'(4'b0100));
        set_slot(0, 1'b1, 22'h300);
        wait_req();
        check("dl_req_addr", 64'(sdram_addr), 64'(22'h300));
        downloading = 1'b1;
        set_slot(0, 1'b0, 22'h300);
        settle();
        check("dl_refresh", 64'(refresh_en), 64'(1));
        tick();
        check("dl_req_drop", 64'(sdram_req), 64'(0));
        check("dl_ok_clear", 64'(slot_ok), 64'(0));
        check("dl_state", 64'(st_dbg), 64'(ST_IDLE));
        tick();
        tick();
        check("dl_no_grant", 64'(sdram_req), 64'(0));
        downloading = 1'b0;
        serve(32'h33333333, a);
        check("dl_refetch_addr", 64'(a), 64'(22'h102));
        check("dl_refetch_ok", 64'(slot_ok), 64'(4'b0100));
        check("dl_refetch_dout", 64'(dout_of(2)), 64'(32'h33333333));
        slot_cs = '0;
        tick();

        // Same-cycle ack and data_rdy
        set_slot(3, 1'b1, 22'h3FFFFF);
        wait_req();
        sdram_ack = 1'b1;
        data_rdy  = 1'b1;
        data_read = 32'h44444444;
        tick();
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        check("same_state", 64'(st_dbg), 64'(ST_IDLE));
        check("same_req", 64'(sdram_req), 64'(0));
        check("same_ok", 64'(slot_ok), 64'(4'b1000));
        check("same_dout", 64'(dout_of(3)), 64'(32'h44444444));
        slot_cs = '0;
        tick();

        // Reset mid-WAIT
        set_slot(1, 1'b1, 22'h55);
        wait_req();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        check("rw_in_wait", 64'(st_dbg), 64'(ST_WAIT));
        slot_cs = '0;
        RESET = 1'b1;
        settle();
        check("rw_req", 64'(sdram_req), 64'(0));
        check("rw_ok", 64'(slot_ok), 64'(0));
        check("rw_refresh", 64'(refresh_en), 64'(1));
        check("rw_state", 64'(st_dbg), 64'(ST_IDLE));
        set_slot(2, 1'b1, 22'h102);
        settle();
        check("rw_ok_flushed", 64'(slot_ok), 64'(0));
        slot_cs = '0;
        tick();
        RESET = 1'b0;
        data_rdy  = 1'b1;
        data_read = 32'h55555555;
        tick();
        data_rdy = 1'b0;
        check("rw_no_write", 64'(dout_of(1)), 64'(0));
        check("rw_dout_zero", 64'(|slot_dout), 64'(0));
        check("rw_idle", 64'(st_dbg), 64'(ST_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
